// File: rtl/poly_pkg.sv
// poly_pkg: shared sizes and types for the polynomial sweep datapath.
// Imported by the feeder and by later evaluator stages.
package poly_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_COEFFS = 6;
  localparam int LATENCY    = 5;
  localparam int CNT_WIDTH  = 16;

  typedef logic signed [DATA_WIDTH-1:0] coef_bank_t [NUM_COEFFS];

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-stage shift register of {valid, data}.
// inflight flags valid samples not yet at the output stage.
module valid_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             inflight
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];

  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inflight = inflight | vld_q[i];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/poly_sweep_feeder.sv
// poly_sweep_feeder: shadow/active coefficient banks plus an x sweep
// generator for the degree-5 evaluator, with latency-matched qualifiers.
module poly_sweep_feeder #(
  parameter int DATA_WIDTH = poly_pkg::DATA_WIDTH,
  parameter int NUM_COEFFS = poly_pkg::NUM_COEFFS,
  parameter int LATENCY    = poly_pkg::LATENCY,
  parameter int CNT_WIDTH  = poly_pkg::CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             coef_valid,
  output logic                             coef_ready,
  input  logic [DATA_WIDTH-1:0]            coef_data,
  input  logic                             start,
  input  logic [DATA_WIDTH-1:0]            x_start,
  input  logic [DATA_WIDTH-1:0]            x_step,
  input  logic [CNT_WIDTH-1:0]             count,
  output logic [DATA_WIDTH-1:0]            x,
  output logic [NUM_COEFFS*DATA_WIDTH-1:0] a,
  output logic                             x_valid,
  output logic                             eval_valid,
  output logic [DATA_WIDTH-1:0]            eval_x,
  output logic                             busy,
  output logic                             done
);

  import poly_pkg::*;

  localparam int IDX_W = $clog2(NUM_COEFFS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  feeder_state_t state_q, state_d;

  logic [IDX_W-1:0]      widx_q, widx_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_COEFFS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_COEFFS];
  logic [DATA_WIDTH-1:0] active_q [NUM_COEFFS];
  logic [DATA_WIDTH-1:0] active_d [NUM_COEFFS];
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic                  xv_q, xv_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  zdone_q, zdone_d;

  logic                  dl_valid;
  logic                  dl_inflight;
  logic [DATA_WIDTH-1:0] dl_x;
  logic                  done_now;

  valid_delay_line #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(LATENCY)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_valid (xv_q),
    .in_data  (x_q),
    .out_valid(dl_valid),
    .out_data (dl_x),
    .inflight (dl_inflight)
  );

  assign coef_ready = !pend_q;
  assign done_now   = (state_q == DRAIN) && dl_valid && !dl_inflight;

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    x_d      = x_q;
    step_d   = step_q;
    xv_d     = 1'b0;
    rem_d    = rem_q;
    zdone_d  = 1'b0;

    if (coef_valid && coef_ready) begin
      shadow_d[widx_q] = coef_data;
      if (widx_q == LAST_IDX) begin
        widx_d = '0;
        pend_d = 1'b1;
      end else begin
        widx_d = widx_q + IDX_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        // Commit lands on the same edge as a start, so the sweep sees it.
        if (pend_q) begin
          active_d = shadow_q;
          pend_d   = 1'b0;
        end
        if (start) begin
          step_d = x_step;
          rem_d  = count;
          if (count == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = SWEEP;
            x_d     = x_start;
            xv_d    = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (rem_q == CNT_WIDTH'(1)) begin
          state_d = DRAIN;
        end else begin
          x_d   = x_q + step_q;
          xv_d  = 1'b1;
          rem_d = rem_q - CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (done_now) begin
          state_d = IDLE;
        end else if (!dl_valid && !dl_inflight) begin
          // Empty sweep: nothing to align with, pulse done next cycle.
          state_d = IDLE;
          zdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a = '0;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      a[i*DATA_WIDTH +: DATA_WIDTH] = active_q[i];
    end
  end

  assign x          = x_q;
  assign x_valid    = xv_q;
  assign eval_valid = dl_valid;
  assign eval_x     = dl_x;
  assign busy       = (state_q != IDLE);
  assign done       = done_now | zdone_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      widx_q  <= '0;
      pend_q  <= 1'b0;
      x_q     <= '0;
      step_q  <= '0;
      xv_q    <= 1'b0;
      rem_q   <= '0;
      zdone_q <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      pend_q   <= pend_d;
      x_q      <= x_d;
      step_q   <= step_d;
      xv_q     <= xv_d;
      rem_q    <= rem_d;
      zdone_q  <= zdone_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_poly_sweep_feeder.sv
// tb_poly_sweep_feeder: randomized scenarios checked against a
// cycle-indexed model built from the sweep timing rules.
module tb_poly_sweep_feeder;

  localparam int DW = 16;
  localparam int NC = 6;
  localparam int L  = 5;
  localparam int CW = 16;

  typedef logic [DW-1:0] bank_t [NC];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             coef_valid = 1'b0;
  logic             coef_ready;
  logic [DW-1:0]    coef_data = '0;
  logic             start = 1'b0;
  logic [DW-1:0]    x_start = '0;
  logic [DW-1:0]    x_step = '0;
  logic [CW-1:0]    count = '0;
  logic [DW-1:0]    x;
  logic [NC*DW-1:0] a;
  logic             x_valid;
  logic             eval_valid;
  logic [DW-1:0]    eval_x;
  logic             busy;
  logic             done;

  poly_sweep_feeder #(
    .DATA_WIDTH(DW),
    .NUM_COEFFS(NC),
    .LATENCY   (L),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_valid(coef_valid),
    .coef_ready(coef_ready),
    .coef_data (coef_data),
    .start     (start),
    .x_start   (x_start),
    .x_step    (x_step),
    .count     (count),
    .x         (x),
    .a         (a),
    .x_valid   (x_valid),
    .eval_valid(eval_valid),
    .eval_x    (eval_x),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      busy_last = -100;
  int      pend_cyc = 0;
  bit      pend = 1'b0;
  bit      ld_active = 1'b0;
  int      ld_idx = 0;
  bank_t   ld_bank;
  bank_t   pend_bank;
  bank_t   exp_a;
  logic [DW-1:0] last_x = '0;

  function automatic logic [NC*DW-1:0] pack(input bank_t b);
    logic [NC*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = b[i];
    return r;
  endfunction

  // One clock: drive the coefficient stream, advance the bank model.
  task automatic tick();
    bit acc;
    coef_valid = ld_active;
    coef_data  = ld_bank[ld_idx];
    acc = ld_active && coef_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && pend && (cyc - 1 >= pend_cyc) && (cyc - 1 > busy_last)) begin
      exp_a = pend_bank;
      pend  = 1'b0;
    end
    if (!rst && acc) begin
      if (ld_idx == NC - 1) begin
        ld_active = 1'b0;
        ld_idx    = 0;
        pend      = 1'b1;
        pend_bank = ld_bank;
        pend_cyc  = cyc;
      end else begin
        ld_idx++;
      end
    end
    coef_valid = ld_active;
    coef_data  = ld_bank[ld_idx];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({x, x_valid, eval_valid, eval_x, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outs got x=%h xv=%b ev=%b ex=%h busy=%b done=%b want all 0",
               x, x_valid, eval_valid, eval_x, busy, done);
    end
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", a);
    end
    checks++;
    if (coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", coef_ready);
    end
  endtask

  task automatic test_coef_load();
    bank_t b1, b2;
    int n;
    for (int i = 0; i < NC; i++) begin
      b1[i] = DW'(i + 1);
      b2[i] = DW'($urandom);
    end
    ld_bank = b1; ld_idx = 0; ld_active = 1'b1; n = 0;
    while (ld_active && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != NC) begin
      errors++;
      $display("FAIL load_cycles got %0d want %0d", n, NC);
    end
    checks++;
    if (coef_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_drop got %b want 0", coef_ready);
    end
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL load_a_early got %h want 0", a);
    end
    // Second bank offered while the first is still pending must stall.
    ld_bank = b2; ld_idx = 0; ld_active = 1'b1;
    tick();
    checks++;
    if (a !== pack(b1)) begin
      errors++;
      $display("FAIL load_commit got %h want %h", a, pack(b1));
    end
    checks++;
    if (coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_back got %b want 1", coef_ready);
    end
    n = 0;
    while (ld_active && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (a !== pack(b2) || n >= 20) begin
      errors++;
      $display("FAIL load_stall_bank got %h want %h", a, pack(b2));
    end
  endtask

  task automatic test_sweep(input logic [DW-1:0] xs, input logic [DW-1:0] st,
                            input int cnt, input bit poke, input bit load_mid,
                            input int tail, input string name);
    int t, span, done_c;
    logic          exp_xv, exp_ev;
    logic [DW-1:0] exp_ex;
    if (load_mid) begin
      for (int i = 0; i < NC; i++) ld_bank[i] = DW'($urandom);
      ld_idx = 0;
      ld_active = 1'b1;
    end
    x_start = xs; x_step = st; count = CW'(cnt); start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
    span = (cnt > 0) ? cnt + L : 1;
    done_c = (cnt > 0) ? cnt + L : 2;
    busy_last = t + span;
    for (int c = 1; c <= span + tail; c++) begin
      exp_xv = (cnt > 0) && (c <= cnt);
      exp_ev = (cnt > 0) && (c >= 1 + L) && (c <= cnt + L);
      if (exp_xv) last_x = xs + DW'(c - 1) * st;
      checks++;
      if (x_valid !== exp_xv) begin
        errors++;
        $display("FAIL %s x_valid c=%0d got %b want %b", name, c, x_valid, exp_xv);
      end
      checks++;
      if (x !== last_x) begin
        errors++;
        $display("FAIL %s x c=%0d got %h want %h", name, c, x, last_x);
      end
      checks++;
      if (eval_valid !== exp_ev) begin
        errors++;
        $display("FAIL %s eval_valid c=%0d got %b want %b", name, c, eval_valid, exp_ev);
      end
      if (exp_ev) begin
        exp_ex = xs + DW'(c - 1 - L) * st;
        checks++;
        if (eval_x !== exp_ex) begin
          errors++;
          $display("FAIL %s eval_x c=%0d got %h want %h", name, c, eval_x, exp_ex);
        end
      end
      checks++;
      if (done !== (c == done_c)) begin
        errors++;
        $display("FAIL %s done c=%0d got %b want %b", name, c, done, c == done_c);
      end
      checks++;
      if (busy !== (c <= span)) begin
        errors++;
        $display("FAIL %s busy c=%0d got %b want %b", name, c, busy, c <= span);
      end
      checks++;
      if (a !== pack(exp_a)) begin
        errors++;
        $display("FAIL %s a c=%0d got %h want %h", name, c, a, pack(exp_a));
      end
      checks++;
      if (coef_ready !== !pend) begin
        errors++;
        $display("FAIL %s coef_ready c=%0d got %b want %b", name, c, coef_ready, !pend);
      end
      start = poke && (c == 2);
      if (start) begin
        x_start = DW'($urandom); x_step = DW'($urandom); count = CW'(3);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_sweep(DW'($urandom), DW'($urandom), 4, 1'b0, 1'b0, 0, "b2b_a");
    test_sweep(DW'($urandom), DW'($urandom), 3, 1'b0, 1'b0, 2, "b2b_b");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NC; i++) ld_bank[i] = DW'($urandom);
      ld_idx = 0; ld_active = 1'b1; n = 0;
      while (ld_active && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (ld_active) begin
        errors++;
        $display("FAIL rand_load r=%0d got stuck want accepted", r);
        ld_active = 1'b0;
      end
      if (r % 2 == 1) tick();
      test_sweep(DW'($urandom), DW'($urandom), int'($urandom_range(0, 12)),
                 1'b0, 1'b0, 2, "rand");
    end
  endtask

  task automatic test_reset_mid_sweep();
    x_start = DW'($urandom); x_step = DW'($urandom); count = CW'(8);
    start = 1'b1;
    busy_last = cyc + 100;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < NC; i++) exp_a[i] = '0;
    pend = 1'b0; ld_active = 1'b0; ld_idx = 0; last_x = '0;
    busy_last = cyc;
    checks++;
    if ({x, x_valid, eval_valid, eval_x, busy, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outs got x=%h xv=%b ev=%b ex=%h busy=%b done=%b want all 0",
               x, x_valid, eval_valid, eval_x, busy, done);
    end
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL rst_mid_a got %h want 0", a);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready got %b want 1", coef_ready);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({eval_valid, done, x_valid, busy} !== 4'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet i=%0d got ev=%b done=%b xv=%b busy=%b want 0",
                 i, eval_valid, done, x_valid, busy);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      ld_bank[i] = '0; pend_bank[i] = '0; exp_a[i] = '0;
    end
    test_reset();
    test_coef_load();
    test_sweep(16'hFFFE, 16'd1, 5, 1'b0, 1'b0, 2, "basic");
    test_sweep(16'd32766, 16'd1, 3, 1'b0, 1'b0, 2, "wrap");
    test_sweep(DW'($urandom), DW'($urandom), 0, 1'b0, 1'b0, 2, "zero");
    test_sweep(DW'($urandom), DW'($urandom), 20, 1'b1, 1'b1, 2, "reload");
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    test_sweep(DW'($urandom), DW'($urandom), 6, 1'b0, 1'b0, 2, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/poly_sweep_feeder.md
# poly_sweep_feeder

Upstream feeder for the degree-5 polynomial evaluator. Loads six signed coefficients over a valid/ready stream into a shadow bank, commits them atomically to an active bank between sweeps, and generates a per-cycle sweep of `x` values (start, step, count) driving the evaluator's `x` and `a[0:5]` inputs. A delay line matches the evaluator's fixed latency so downstream logic receives `eval_valid` and `eval_x` aligned with `fx`.

## Interface
- `DATA_WIDTH`, 16: width of `x`, coefficients and sweep parameters (signed two's complement).
- `NUM_COEFFS`, 6: coefficients per bank, indices 0..5, `a[i]` multiplies x^i.
- `LATENCY`, 5: evaluator pipeline depth in cycles, from `x` sampled to `fx` valid.
- `CNT_WIDTH`, 16: width of sweep sample count.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coef_valid`  in  1  coefficient word present.
- `coef_ready`  out  1  feeder accepts coefficient word this cycle.
- `coef_data`  in  DATA_WIDTH  coefficient word, sent in order a[0] first, a[5] last.
- `start`  in  1  single-cycle sweep request.
- `x_start`  in  DATA_WIDTH  first x of sweep, sampled with `start`.
- `x_step`  in  DATA_WIDTH  signed increment, sampled with `start`.
- `count`  in  CNT_WIDTH  number of samples, sampled with `start`.
- `x`  out  DATA_WIDTH  to evaluator `x`, registered.
- `a`  out  DATA_WIDTH × NUM_COEFFS  active coefficient bank, registered.
- `x_valid`  out  1  `x` is a live sweep sample this cycle.
- `eval_valid`  out  1  `x_valid` delayed by LATENCY; qualifies evaluator `fx`.
- `eval_x`  out  DATA_WIDTH  `x` delayed by LATENCY.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when last sample's `eval_valid` is high.

## Operation
- Coefficient load: write index `widx` (0..5). Word accepted when `coef_valid && coef_ready`; stored to `shadow[widx]`, `widx` increments. Accepting index 5 sets `pending`, resets `widx` to 0.
- `coef_ready = !pending`. While pending, further words stall.
- Commit: in IDLE with `pending` set, copy shadow → active, clear `pending` (one cycle). Never commits during SWEEP/DRAIN; the active bank is constant for a whole sweep.
- States: IDLE, SWEEP, DRAIN.
  - IDLE: `start` latches parameters; if `count` = 0 → DRAIN with no samples, else → SWEEP. If `start` and commit coincide, the commit happens that same cycle and the sweep uses the new bank.
  - SWEEP: drive `x` = x_start + k·x_step (k = 0..count-1, wrap modulo 2^DATA_WIDTH, no saturation), `x_valid` = 1. After the k = count-1 sample → DRAIN.
  - DRAIN: `x_valid` = 0; wait until delay line empty of valid samples, pulse `done` coincident with last `eval_valid`, → IDLE. For count = 0, `done` pulses the cycle after entering DRAIN.
- `start` while `busy` is ignored (no latch, no error).
- `x` holds last value when `x_valid` = 0.

## Timing
- `start` at edge t (IDLE) → first `x_valid` at t+1; samples at t+1..t+count, one per cycle, no gaps, no backpressure.
- `eval_valid`/`eval_x` at t+1+LATENCY..t+count+LATENCY; `done` at t+count+LATENCY; `busy` high t+1..t+count+LATENCY, low at t+count+LATENCY+1; next `start` accepted that cycle.
- Coefficient word accepted at edge e visible in shadow at e+1; commit to `a` one cycle after pending is set in IDLE.
- Reset (any state, including mid-sweep or mid-load): state IDLE, `widx` 0, `pending` 0, shadow and active banks 0, `x` 0, `x_valid` 0, delay line cleared (`eval_valid` 0, `eval_x` 0), `busy` 0, `done` 0, `coef_ready` 1 the cycle after reset deasserts.

## Structure
- Shared package `poly_pkg`: DATA_WIDTH, NUM_COEFFS, LATENCY defaults, `coef_bank_t` (unpacked array type), `feeder_state_t` enum {IDLE, SWEEP, DRAIN}.
- One sub-module `valid_delay_line` (LATENCY-deep shift register of {valid, x}, synchronous clear on `rst`); also reusable by later stages.

## Test plan
- Load 1,2,3,4,5,6 with `coef_valid` held high → `coef_ready` drops after 6th word, `a` = {1,2,3,4,5,6} two cycles later, `coef_ready` returns high.
- Sweep x_start=−2, x_step=1, count=5 → `x_valid` 5 cycles, x = −2,−1,0,1,2; `eval_x` same sequence 5 cycles later; `done` at t+10.
- x_start=32766, x_step=1, count=3 → x = 32766, 32767, −32768 (wrap).
- Reload coefficients mid-sweep → `a` unchanged until DRAIN→IDLE, then commits; `start` during sweep ignored.
- count=0 → no `x_valid`, `done` two cycles after `start`, `busy` one cycle.
- Assert `rst` mid-sweep (after sample 2 of 8) → next cycle all outputs 0, no `eval_valid`, no `done`; new `start` runs a clean sweep.
